// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - programmable interval timer: prescaled 12-bit up-counter with start/hold/stop sequencing
module timer_ctrl #(
    parameter int WIDTH = 12,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [PRE_W-1:0] cfg_prescale,
    input  logic             cfg_periodic,
    input  logic             start,
    input  logic             hold,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           st, st_n;
    logic [WIDTH-1:0] period_r;
    logic [PRE_W-1:0] pre_r;
    logic             periodic_r;
    logic [PRE_W-1:0] pc, pc_n;
    logic [WIDTH-1:0] count_n;
    logic             tick_n;
    logic             advance;
    logic             cfg_load;

    assign cfg_load = cfg_we && (st == IDLE || st == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= IDLE;
            count      <= '0;
            pc         <= '0;
            tick       <= 1'b0;
            period_r   <= '0;
            pre_r      <= '0;
            periodic_r <= 1'b0;
        end else begin
            st    <= st_n;
            count <= count_n;
            pc    <= pc_n;
            tick  <= tick_n;
            if (cfg_load) begin
                period_r   <= cfg_period;
                pre_r      <= cfg_prescale;
                periodic_r <= cfg_periodic;
            end
        end
    end

    always_comb begin
        st_n    = st;
        count_n = count;
        pc_n    = pc;
        tick_n  = 1'b0;
        advance = 1'b0;
        if (stop) begin
            st_n    = IDLE;
            count_n = '0;
            pc_n    = '0;
        end else begin
            case (st)
                IDLE, DONE: begin
                    if (start) begin
                        st_n    = RUN;
                        count_n = '0;
                        pc_n    = '0;
                    end
                end
                RUN: begin
                    if (hold) st_n = HOLD;
                    else      advance = 1'b1;
                end
                HOLD: begin
                    // Leaving HOLD counts on the same edge, so each HOLD cycle costs exactly one cycle.
                    if (!hold) begin
                        st_n    = RUN;
                        advance = 1'b1;
                    end
                end
                default: st_n = IDLE;
            endcase
        end
        if (advance) begin
            if (pc == pre_r) begin
                pc_n = '0;
                if (count == period_r) begin
                    tick_n = 1'b1;
                    if (periodic_r) count_n = '0;
                    else            st_n    = DONE;
                end else begin
                    count_n = count + WIDTH'(1);
                end
            end else begin
                pc_n = pc + PRE_W'(1);
            end
        end
    end

    assign state = st;
    assign busy  = (st == RUN) || (st == HOLD);
    assign done  = (st == DONE);

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - randomized self-checking bench for timer_ctrl against an elapsed-cycle model
module tb_timer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [11:0] cfg_period;
    logic [7:0]  cfg_prescale;
    logic        cfg_periodic;
    logic        start;
    logic        hold;
    logic        stop;
    logic [11:0] count;
    logic        tick;
    logic        busy;
    logic        done;
    logic [1:0]  state;

    timer_ctrl #(.WIDTH(12), .PRE_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_period(cfg_period),
        .cfg_prescale(cfg_prescale), .cfg_periodic(cfg_periodic), .start(start),
        .hold(hold), .stop(stop), .count(count), .tick(tick), .busy(busy),
        .done(done), .state(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e0    = 0;

    // Model: state code, counting edges elapsed since start, config, and held DONE value.
    int ms, adv, m_p, m_s, m_per, done_cnt, m_tick;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        if (ms == 0) return 0;
        if (ms == 3) return done_cnt;
        return adv / (m_s + 1);
    endfunction

    task automatic model_reset();
        ms = 0; adv = 0; m_p = 0; m_s = 0; m_per = 0; done_cnt = 0; m_tick = 0;
    endtask

    task automatic model_edge();
        int old_ms;
        int span;
        bit counting;
        old_ms   = ms;
        counting = 1'b0;
        m_tick   = 0;
        span     = (m_p + 1) * (m_s + 1);
        if (stop) begin
            ms = 0; adv = 0;
        end else begin
            case (ms)
                0, 3: if (start) begin ms = 1; adv = 0; end
                1: if (hold) ms = 2; else counting = 1'b1;
                default: if (!hold) begin ms = 1; counting = 1'b1; end
            endcase
        end
        if (counting) begin
            adv++;
            if (adv == span) begin
                m_tick = 1;
                if (m_per != 0) adv = 0;
                else begin ms = 3; done_cnt = m_p; end
            end
        end
        if (cfg_we && (old_ms == 0 || old_ms == 3)) begin
            m_p = int'(cfg_period); m_s = int'(cfg_prescale); m_per = int'(cfg_periodic);
        end
    endtask

    task automatic check_outs();
        chk("count", count, m_count());
        chk("tick", tick, m_tick);
        chk("state", state, ms);
        chk("busy", busy, (ms == 1 || ms == 2));
        chk("done", done, (ms == 3));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_outs();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic restart(int p, int s, int per);
        stop = 1'b1; step(); stop = 1'b0;
        cfg_we = 1'b1; cfg_period = 12'(p); cfg_prescale = 8'(s); cfg_periodic = per[0];
        step();
        cfg_we = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        e0 = cyc;
    endtask

    task automatic measure_ticks(string tag, int nticks, int interval, int budget);
        int last = -1;
        int seen = 0;
        while (seen < nticks && budget > 0) begin
            step();
            budget--;
            if (tick) begin
                if (last >= 0) chk(tag, cyc - last, interval);
                last = cyc;
                seen++;
            end
        end
        if (seen < nticks) chk({tag, "_timeout"}, seen, nticks);
    endtask

    initial begin
        int budget;
        reset = 1'b1; cfg_we = 1'b0; cfg_period = '0; cfg_prescale = '0; cfg_periodic = 1'b0;
        start = 1'b0; hold = 1'b0; stop = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_outs();
        run(10);
        start = 1'b1; step(); start = 1'b0;
        chk("start_state", state, 1);

        // Periodic P=3: five periods at S=0, then S=2.
        restart(3, 0, 1);
        measure_ticks("per_p3_s0", 6, 4, 40);
        restart(3, 2, 1);
        measure_ticks("per_p3_s2", 4, 12, 80);

        // One-shot P=2 S=1: tick and done together six edges after start.
        restart(2, 1, 0);
        run(5);
        chk("os_done_early", done, 0);
        step();
        chk("os_done", done, 1);
        chk("os_tick", tick, 1);
        chk("os_count", count, 2);
        run(5);
        chk("os_hold_count", count, 2);
        chk("os_no_retick", tick, 0);
        start = 1'b1; step(); start = 1'b0;
        chk("os_restart_count", count, 0);
        chk("os_restart_state", state, 1);

        // Hold for 7 cycles at count=2 delays the first tick by 7; config write ignored.
        restart(5, 0, 1);
        run(2);
        hold = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cfg_we = (i == 3); cfg_period = 12'd1;
            step();
            chk("hold_count", count, 2);
            chk("hold_state", state, 2);
        end
        cfg_we = 1'b0;
        hold = 1'b0;
        budget = 50;
        while (!tick && budget > 0) begin step(); budget--; end
        chk("hold_delay", cyc - e0, 13);
        measure_ticks("hold_cfg_ignored", 2, 6, 40);

        // Full-range period and degenerate P=0.
        restart(4095, 0, 1);
        measure_ticks("per_p4095", 3, 4096, 13000);
        restart(0, 0, 1);
        measure_ticks("per_p0", 5, 1, 20);
        chk("p0_count", count, 0);

        // Stop wins over start; asynchronous reset mid-run.
        restart(20, 0, 1);
        run(7);
        chk("pre_stop_count", count, 7);
        stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
        chk("stop_state", state, 0);
        chk("stop_count", count, 0);
        start = 1'b1; step(); start = 1'b0;
        run(5);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_count", count, 0);
        chk("rst_state", state, 0);
        chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        check_outs();

        // Randomized control and config traffic.
        for (int i = 0; i < 4000; i++) begin
            cfg_we       = ($urandom_range(0, 19) == 0);
            cfg_period   = 12'($urandom_range(0, 15));
            cfg_prescale = 8'($urandom_range(0, 3));
            cfg_periodic = 1'($urandom_range(0, 1));
            start        = ($urandom_range(0, 19) == 0);
            stop         = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) hold = ~hold;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
